rle_uart_tx: RTL and testbench
==============================

// Module: rle_uart_tx
// PURPOSE
//  Downstream consumer of the memory reader's run-length output: pairs each symbol (data_in/data_valid)
//  with its run count (rep_in/rep_valid), buffers pairs in a small FIFO, and serialises each pair
//  as two UART 8N1 frames (symbol first, then count) on tx. Sits between reader and the chip pad.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (>=2); 868 = 115200 baud at 100 MHz
//  FIFO_DEPTH    8    pair FIFO entries, power of two, >=2
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  synchronous, active-high
//  data_in      in   8  run symbol from reader
//  data_valid   in   1  1-cycle strobe, data_in valid
//  rep_in       in   8  run length from reader (passed through unmodified, 0..255)
//  rep_valid    in   1  1-cycle strobe, rep_in valid
//  stream_done  in   1  reader finished; level or pulse, sampled rising edge only
//  tx           out  1  UART line, idle high
//  busy         out  1  1 while FIFO non-empty or serialiser not IDLE
//  overflow     out  1  sticky: a pair was dropped because FIFO full
//  proto_err    out  1  sticky: pairing violation (see below)
//  tx_done      out  1  1-cycle pulse: stream fully transmitted after stream_done
// BEHAVIOUR
//  Reset (sync, any state, mid-frame included): tx=1, busy=0, overflow=0, proto_err=0, tx_done=0;
//   FIFO emptied, pending symbol cleared, FSM->IDLE. A frame in flight is abandoned (line held high).
//  Pairing: data_valid latches data_in into pending register, sets pend=1. rep_valid with pend=1
//   forms pair {pending,rep_in}, pushes to FIFO, clears pend. Same-cycle data_valid&rep_valid with
//   pend=0: pair {data_in,rep_in} pushed directly. rep_valid with pend=0 and no data_valid: ignored,
//   proto_err<=1. data_valid with pend=1 and no rep_valid: old symbol overwritten, proto_err<=1.
//  FIFO full at push: pair dropped, overflow<=1, FIFO contents unchanged. Simultaneous push & pop
//   when full: pop first, push accepted.
//  FSM: IDLE -> LOAD (FIFO non-empty; pop pair, byte_sel=0) -> START (tx=0, CLKS_PER_BIT cycles)
//   -> DATA (8 bits LSB first, CLKS_PER_BIT each) -> STOP (tx=1, CLKS_PER_BIT) -> byte_sel==0 ?
//   START with count byte, byte_sel=1 : IDLE. No idle gap between symbol and count frames.
//  Latency: push at edge N with FSM in IDLE -> LOAD at N+1 -> tx falls at edge N+2.
//  Back-to-back pairs: STOP of count frame -> IDLE -> LOAD; 2 cycles of idle-high between pairs.
//  Bit counter 3 bits, baud counter $clog2(CLKS_PER_BIT) bits, wrap to 0 at CLKS_PER_BIT-1.
//  End of stream: done_seen set on stream_done rising edge (held until tx_done). When done_seen
//   & FIFO empty & pend=0 & FSM IDLE: tx_done pulses 1 cycle, done_seen clears. If pend=1 at
//   that point, proto_err<=1 and pending symbol discarded before tx_done.
// CONFIGURATION
//  RLE_TX_CHECKSUM_EN defined: running XOR of every byte sent (symbols and counts) since last
//   tx_done/reset; at end of stream FSM goes IDLE -> CSUM frame (one 8N1 frame of the XOR) ->
//   IDLE, then tx_done pulses on cycle after CSUM's STOP ends; XOR cleared with tx_done.
//  Not defined: no CSUM state, no XOR register; tx_done as described above.
// STRUCTURE
//  Package rle_pkg: typedef struct packed {logic [7:0] sym; logic [7:0] cnt;} rle_pair_t;
//   typedef enum {IDLE, LOAD, START, DATA, STOP, CSUM} tx_state_e; localparam UART_DATA_BITS=8.
//  Sub-module rle_pair_fifo: sync FIFO of rle_pair_t, FIFO_DEPTH, push/pop/full/empty,
//   registered read data valid the cycle after pop. All pairing/FSM logic stays in rle_uart_tx.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4; bench UART monitor samples mid-bit)
//  1. data_in=8'hA5 strobe, 3 cycles later rep_in=8'h03 strobe -> frames 0xA5 then 0x03; tx low at
//     2nd edge after rep_valid; 80 cycles total; busy high throughout.
//  2. Same-cycle data_valid(8'h41)&rep_valid(8'hFF) with pend=0 -> frames 0x41, 0xFF; proto_err=0.
//  3. 6 pairs pushed back-to-back while first frame in flight -> first 5 transmitted in order
//     (1 in flight + 4 buffered), 6th dropped, overflow=1 sticky until reset.
//  4. rep_valid alone -> nothing sent, proto_err=1; two data_valid (0x11,0x22) then rep 0x02 -> sends
//     0x22,0x02, proto_err=1.
//  5. Pairs (0x10,0x02),(0x20,0x01) then stream_done -> tx_done single pulse after last STOP;
//     with RLE_TX_CHECKSUM_EN extra frame 0x33 (0x10^0x02^0x20^0x01) precedes tx_done.
//  6. reset asserted mid-DATA of a frame with 2 pairs queued -> next cycle tx=1, busy=0, flags 0;
//     no further frames; new pair afterwards transmits normally.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types for the run-length UART transmitter: the buffered pair and the serialiser states.
package rle_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef struct packed {
    logic [7:0] sym;
    logic [7:0] cnt;
  } rle_pair_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    CSUM  = 3'd5
  } tx_state_e;

endpackage

// File: rtl/rle_pair_fifo.sv
// Synchronous FIFO of symbol/count pairs; read data is registered and valid the cycle after a pop.
module rle_pair_fifo
  import rle_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  rle_pair_t pair_i,
  input  logic      pop_i,
  output rle_pair_t rd_pair_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int AW = $clog2(DEPTH);

  rle_pair_t  mem_q [DEPTH];
  rle_pair_t  rd_pair_q, rd_pair_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push while full is still accepted.
  assign do_push = push_i && (!full_o || do_pop);
  assign rd_pair_o = rd_pair_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_pair_d = rd_pair_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop) begin
      rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
      rd_pair_d = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_pair_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_pair_q <= rd_pair_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= pair_i;
  end

endmodule

// File: rtl/rle_uart_tx.sv
// Pairs run symbols with run counts, buffers the pairs and sends each as two UART 8N1 frames.
// Define RLE_TX_CHECKSUM_EN to append an XOR checksum frame before tx_done.
module rle_uart_tx
  import rle_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  // data_valid / rep_valid are single-cycle strobes with no backpressure: each strobe is
  // consumed on the rising edge it is high, and a pair that finds the FIFO full is lost.
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic [7:0] rep_in,
  input  logic       rep_valid,
  input  logic       stream_done,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic       proto_err,
  output logic       tx_done,
  output logic [2:0] dbg_state_o
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic        byte_sel_q, byte_sel_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_sym_q, pend_sym_d;
  logic        overflow_q, overflow_d;
  logic        proto_err_q, proto_err_d;
  logic        done_seen_q, done_seen_d;
  logic        sd_prev_q;
`ifdef RLE_TX_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
  logic        csum_sent_q, csum_sent_d;
`endif

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  rle_pair_t   push_pair, rd_pair;
  logic        baud_last, end_ready, stream_idle;

  rle_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (fifo_push),
    .pair_i    (push_pair),
    .pop_i     (fifo_pop),
    .rd_pair_o (rd_pair),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign baud_last   = (baud_q == BAUD_LAST);
  assign end_ready   = done_seen_q && fifo_empty && (state_q == IDLE);
  assign stream_idle = end_ready && !pend_q;
`ifdef RLE_TX_CHECKSUM_EN
  assign tx_done = stream_idle && csum_sent_q;
`else
  assign tx_done = stream_idle;
`endif
  assign busy        = !fifo_empty || (state_q != IDLE);
  assign overflow    = overflow_q;
  assign proto_err   = proto_err_q;
  assign dbg_state_o = state_q;
  assign done_seen_d = (done_seen_q && !tx_done) || (stream_done && !sd_prev_q);

  always_comb begin
    fifo_push   = 1'b0;
    push_pair   = '0;
    pend_d      = pend_q;
    pend_sym_d  = pend_sym_q;
    proto_err_d = proto_err_q;
    if (rep_valid) begin
      if (pend_q) begin
        fifo_push  = 1'b1;
        push_pair  = '{sym: pend_sym_q, cnt: rep_in};
        pend_d     = data_valid;
        if (data_valid) pend_sym_d = data_in;
      end else if (data_valid) begin
        fifo_push = 1'b1;
        push_pair = '{sym: data_in, cnt: rep_in};
      end else begin
        proto_err_d = 1'b1;
      end
    end else if (data_valid) begin
      if (pend_q) proto_err_d = 1'b1;
      pend_d     = 1'b1;
      pend_sym_d = data_in;
    end else if (end_ready && pend_q) begin
      // Stream ended with a symbol still waiting for its count: drop it.
      pend_d      = 1'b0;
      proto_err_d = 1'b1;
    end
    overflow_d = overflow_q || (fifo_push && fifo_full && !fifo_pop);
  end

  always_comb begin
    state_d    = state_q;
    byte_sel_d = byte_sel_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    fifo_pop   = 1'b0;
`ifdef RLE_TX_CHECKSUM_EN
    xor_d       = xor_q;
    csum_sent_d = csum_sent_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = LOAD;
        end
`ifdef RLE_TX_CHECKSUM_EN
        else if (stream_idle && !csum_sent_q) state_d = CSUM;
`endif
      end
      LOAD: begin
        shreg_d    = rd_pair.sym;
        cnt_d      = rd_pair.cnt;
        byte_sel_d = 1'b0;
        baud_d     = '0;
        state_d    = START;
`ifdef RLE_TX_CHECKSUM_EN
        xor_d = xor_q ^ rd_pair.sym ^ rd_pair.cnt;
`endif
      end
      START: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d = '0;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            shreg_d    = cnt_q;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef RLE_TX_CHECKSUM_EN
      CSUM: begin
        shreg_d     = xor_q;
        byte_sel_d  = 1'b1;
        baud_d      = '0;
        csum_sent_d = 1'b1;
        state_d     = START;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef RLE_TX_CHECKSUM_EN
    if (tx_done) begin
      xor_d       = '0;
      csum_sent_d = 1'b0;
    end
`endif
  end

  always_comb begin
    tx = 1'b1;
    if (state_q == START) tx = 1'b0;
    else if (state_q == DATA) tx = shreg_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_sel_q  <= 1'b0;
      baud_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_sym_q  <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
      done_seen_q <= 1'b0;
      sd_prev_q   <= 1'b0;
`ifdef RLE_TX_CHECKSUM_EN
      xor_q       <= '0;
      csum_sent_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      byte_sel_q  <= byte_sel_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_sym_q  <= pend_sym_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
      done_seen_q <= done_seen_d;
      sd_prev_q   <= stream_done;
`ifdef RLE_TX_CHECKSUM_EN
      xor_q       <= xor_d;
      csum_sent_q <= csum_sent_d;
`endif
    end
  end

endmodule

// File: tb/tb_rle_uart_tx.sv
// Bench for rle_uart_tx: a mid-bit UART monitor checks every received frame against an expected queue.
module tb_rle_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic [7:0] rep_in = '0;
  logic       rep_valid = 1'b0;
  logic       stream_done = 1'b0;
  logic       tx, busy, overflow, proto_err, tx_done;
  logic [2:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  bit mon_busy = 1'b0;
  logic [7:0] mon_rx, mon_exp;
  logic mon_start_ok, mon_stop, mon_abort;

  rle_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .rep_in      (rep_in),
    .rep_valid   (rep_valid),
    .stream_done (stream_done),
    .tx          (tx),
    .busy        (busy),
    .overflow    (overflow),
    .proto_err   (proto_err),
    .tx_done     (tx_done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // UART monitor: offset 0 is the first falling edge of clk with the line low.
  always begin
    @(negedge clk);
    if (!reset && tx === 1'b0) begin
      mon_busy = 1'b1;
      mon_abort = 1'b0;
      mon_start_ok = 1'b0;
      mon_stop = 1'b0;
      mon_rx = '0;
      for (int off = 1; off <= 9 * CPB + CPB / 2; off++) begin
        @(negedge clk);
        if (reset) mon_abort = 1'b1;
        if ((off % CPB) == CPB / 2) begin
          int idx;
          idx = off / CPB;
          if (idx == 0) mon_start_ok = (tx === 1'b0);
          else if (idx <= 8) mon_rx[idx-1] = tx;
          else mon_stop = tx;
        end
      end
      if (!mon_abort) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL uart_unexpected_frame: got %02h expected no frame", mon_rx);
        end else begin
          mon_exp = exp_q.pop_front();
          if (!mon_start_ok || mon_stop !== 1'b1 || mon_rx !== mon_exp) begin
            tests_failed++;
            $display("FAIL uart_frame: got %02h start_ok=%0b stop=%0b expected %02h", mon_rx,
                     mon_start_ok, mon_stop, mon_exp);
          end
        end
      end
      mon_busy = 1'b0;
    end
  end

  // driver tasks (called right after a falling edge)
  task automatic drive_data(input logic [7:0] s);
    data_in = s; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic drive_rep(input logic [7:0] c);
    rep_in = c; rep_valid = 1'b1;
    @(negedge clk);
    rep_valid = 1'b0;
  endtask

  task automatic drive_pair(input logic [7:0] s, input logic [7:0] c);
    data_in = s; rep_in = c; data_valid = 1'b1; rep_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0; rep_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (45) @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !mon_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({tx, busy, overflow, proto_err, tx_done} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got tx,busy,ovf,perr,done=%b expected 10000",
               {tx, busy, overflow, proto_err, tx_done});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_single_pair();
    int cnt;
    bit ok;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h03);
    drive_data(8'hA5);
    repeat (2) @(negedge clk);
    drive_rep(8'h03);
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_push_cycle: got tx=%b busy=%b expected tx=1 busy=1", tx, busy);
    end
    @(negedge clk);
    tests_run++;
    if (tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_load_cycle: got tx=%b expected 1", tx);
    end
    @(negedge clk);
    tests_run++;
    if (tx !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_start_edge: got tx=%b expected 0", tx);
    end
    cnt = 3;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    tests_run++;
    if (cnt != 82) begin
      tests_failed++;
      $display("FAIL single_busy_cycles: got %0d expected 82", cnt);
    end
    wait_idle(200, ok);
    tests_run++;
    if (!ok || proto_err !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drain: got ok=%0b perr=%b ovf=%b expected 1 0 0", ok, proto_err, overflow);
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'hFF);
    drive_pair(8'h41, 8'hFF);
    wait_idle(300, ok);
    tests_run++;
    if (!ok || proto_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle: got ok=%0b perr=%b expected ok=1 perr=0", ok, proto_err);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    for (int k = 0; k <= 4; k++) begin
      exp_q.push_back(8'h60 + 8'(k));
      exp_q.push_back(8'(k + 1));
    end
    drive_pair(8'h60, 8'h01);
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      drive_pair(8'h60 + 8'(k), 8'(k + 1));
      if (k == 4) begin
        tests_run++;
        if (overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf_before_full: got %b expected 0", overflow);
        end
      end
    end
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    wait_idle(1000, ok);
    tests_run++;
    if (!ok || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sticky: got ok=%0b ovf=%b expected ok=1 ovf=1", ok, overflow);
    end
  endtask

  task automatic test_proto_err();
    bit ok;
    do_reset();
    drive_rep(8'h77);
    repeat (3) @(negedge clk);
    tests_run++;
    if (proto_err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL perr_lone_rep: got perr=%b busy=%b expected perr=1 busy=0", proto_err, busy);
    end
    do_reset();
    drive_data(8'h11);
    tests_run++;
    if (proto_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL perr_first_data: got %b expected 0", proto_err);
    end
    drive_data(8'h22);
    tests_run++;
    if (proto_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL perr_overwrite: got %b expected 1", proto_err);
    end
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h02);
    drive_rep(8'h02);
    wait_idle(300, ok);
    tests_run++;
    if (!ok || proto_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL perr_overwrite_drain: got ok=%0b perr=%b expected ok=1 perr=1", ok, proto_err);
    end
  endtask

  task automatic test_stream_done();
    int pulses;
    logic prev_busy, busy_before, mon_clear;
    do_reset();
    exp_q.push_back(8'h10); exp_q.push_back(8'h02);
    exp_q.push_back(8'h20); exp_q.push_back(8'h01);
`ifdef RLE_TX_CHECKSUM_EN
    exp_q.push_back(8'h33);
`endif
    drive_pair(8'h10, 8'h02);
    drive_pair(8'h20, 8'h01);
    stream_done = 1'b1;
    pulses = 0;
    prev_busy = busy;
    busy_before = 1'b0;
    mon_clear = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        pulses++;
        busy_before = prev_busy;
        mon_clear = (exp_q.size() == 0) && !mon_busy;
      end
      prev_busy = busy;
    end
    stream_done = 1'b0;
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL done_pulse_count: got %0d expected 1", pulses);
    end
    tests_run++;
    if (busy_before !== 1'b1 || mon_clear !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_after_last_stop: got busy_before=%b all_frames=%b expected 1 1",
               busy_before, mon_clear);
    end
  endtask

  task automatic test_stream_pending();
    int pulses;
    do_reset();
`ifdef RLE_TX_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    drive_data(8'h55);
    stream_done = 1'b1;
    @(negedge clk);
    stream_done = 1'b0;
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 1 || proto_err !== 1'b1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL done_pending_discard: got pulses=%0d perr=%b left=%0d expected 1 1 0",
               pulses, proto_err, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int lows;
    bit ok;
    do_reset();
    drive_rep(8'h99);
    exp_q.push_back(8'hA1);
    drive_pair(8'hA1, 8'hB1);
    drive_pair(8'hA2, 8'hB2);
    drive_pair(8'hA3, 8'hB3);
    repeat (8) @(negedge clk);
    tests_run++;
    if (dbg_state !== 3'd3) begin
      tests_failed++;
      $display("FAIL rst_mid_in_data: got state %0d expected 3", dbg_state);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({tx, busy, overflow, proto_err, tx_done} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got tx,busy,ovf,perr,done=%b expected 10000",
               {tx, busy, overflow, proto_err, tx_done});
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    tests_run++;
    if (lows != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", lows);
    end
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h07);
    drive_pair(8'h5A, 8'h07);
    wait_idle(300, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rst_mid_recover: got drained=%0b expected 1", ok);
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_same_cycle();
    test_overflow();
    test_proto_err();
    test_stream_done();
    test_stream_pending();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
